// File: rtl/synth_pkg.sv
// Shared constants and types for the voice scheduler and its oscillator-side neighbours.
// Sizes here are defaults. Each module re-exposes them as overridable parameters.
package synth_pkg;

    localparam int NUM_VOICES = 16;
    localparam int VIDX_W     = $clog2(NUM_VOICES);
    localparam int TUNE_W     = 32;
    localparam int VEL_W      = 7;

    localparam logic NOTEON  = 1'b1;
    localparam logic NOTEOFF = 1'b0;

    typedef enum logic {
        IDLE,
        SCAN
    } sched_state_t;

endpackage

// File: rtl/voice_scheduler_if.sv
// Slot handshake between the voice scheduler (master) and the shared oscillator datapath (slave).
interface voice_scheduler_if #(
    parameter int VIDX_W = synth_pkg::VIDX_W,
    parameter int TUNE_W = synth_pkg::TUNE_W,
    parameter int VEL_W  = synth_pkg::VEL_W
);

    logic              osc_valid;
    logic              osc_ready;
    logic [VIDX_W-1:0] osc_voice;
    logic [TUNE_W-1:0] osc_phase;
    logic [VEL_W-1:0]  osc_velocity;
    logic              osc_gate;
    logic              osc_last;

    modport master (
        output osc_valid, osc_voice, osc_phase, osc_velocity, osc_gate, osc_last,
        input  osc_ready
    );

    modport slave (
        input  osc_valid, osc_voice, osc_phase, osc_velocity, osc_gate, osc_last,
        output osc_ready
    );

endinterface

// File: rtl/voice_param_table.sv
// Per-voice gate/tuning/velocity/phase storage with an event write port, a phase write port,
// a combinational view of the voice being advanced and a registered slot read.
module voice_param_table #(
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int VIDX_W     = synth_pkg::VIDX_W,
    parameter int TUNE_W     = synth_pkg::TUNE_W,
    parameter int VEL_W      = synth_pkg::VEL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_ev_we,
    input  logic              i_ev_status,
    input  logic [VIDX_W-1:0] i_ev_idx,
    input  logic [TUNE_W-1:0] i_ev_tune,
    input  logic [VEL_W-1:0]  i_ev_vel,
    input  logic              i_ph_we,
    input  logic [VIDX_W-1:0] i_idx,
    input  logic [TUNE_W-1:0] i_ph_data,
    output logic              o_cur_gate,
    output logic [TUNE_W-1:0] o_cur_tune,
    output logic [TUNE_W-1:0] o_cur_phase,
    input  logic              i_rd_en,
    input  logic [VIDX_W-1:0] i_rd_idx,
    output logic              o_rd_gate,
    output logic [VEL_W-1:0]  o_rd_vel,
    output logic [TUNE_W-1:0] o_rd_phase
);

    import synth_pkg::NOTEON, synth_pkg::NOTEOFF;

    logic              r_gate  [NUM_VOICES];
    logic [TUNE_W-1:0] r_tune  [NUM_VOICES];
    logic [VEL_W-1:0]  r_vel   [NUM_VOICES];
    logic [TUNE_W-1:0] r_phase [NUM_VOICES];

    logic              r_rd_gate;
    logic [VEL_W-1:0]  r_rd_vel;
    logic [TUNE_W-1:0] r_rd_phase;

    logic              w_ph_blocked;

    // An event aimed at the voice being advanced owns that entry for the cycle.
    assign w_ph_blocked = i_ev_we && (i_ev_idx == i_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_gate[v]  <= 1'b0;
                r_tune[v]  <= '0;
                r_vel[v]   <= '0;
                r_phase[v] <= '0;
            end
        end else begin
            if (i_ph_we && !w_ph_blocked) begin
                r_phase[i_idx] <= i_ph_data;
            end
            if (i_ev_we) begin
                case (i_ev_status)
                    NOTEON: begin
                        r_gate[i_ev_idx]  <= 1'b1;
                        r_tune[i_ev_idx]  <= i_ev_tune;
                        r_vel[i_ev_idx]   <= i_ev_vel;
                        r_phase[i_ev_idx] <= '0;
                    end
                    NOTEOFF: begin
                        r_gate[i_ev_idx] <= 1'b0;
                    end
                    default: begin
                        r_gate[i_ev_idx] <= r_gate[i_ev_idx];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_gate  <= 1'b0;
            r_rd_vel   <= '0;
            r_rd_phase <= '0;
        end else if (i_rd_en) begin
            r_rd_gate  <= r_gate[i_rd_idx];
            r_rd_vel   <= r_vel[i_rd_idx];
            r_rd_phase <= r_phase[i_rd_idx];
        end
    end

    assign o_cur_gate  = r_gate[i_idx];
    assign o_cur_tune  = r_tune[i_idx];
    assign o_cur_phase = r_phase[i_idx];
    assign o_rd_gate   = r_rd_gate;
    assign o_rd_vel    = r_rd_vel;
    assign o_rd_phase  = r_rd_phase;

endmodule

// File: rtl/voice_scheduler.sv
// Applies SPI note events to the voice table and, once per sample tick, walks every voice
// through one shared phase adder while presenting each slot over a valid/ready handshake.
module voice_scheduler #(
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int VIDX_W     = synth_pkg::VIDX_W,
    parameter int TUNE_W     = synth_pkg::TUNE_W,
    parameter int VEL_W      = synth_pkg::VEL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SPI_note_status,
    input  logic [7:0]        SPI_voice_index,
    input  logic [TUNE_W-1:0] SPI_tuning_code,
    input  logic [VEL_W-1:0]  SPI_velocity,
    input  logic              SPI_ready_flag,
    input  logic              sample_tick,
    voice_scheduler_if.master osc,
    output logic              frame_done,
    output logic              overrun,
    output logic              event_drop
);

    import synth_pkg::sched_state_t, synth_pkg::IDLE, synth_pkg::SCAN;

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [VIDX_W-1:0] r_idx;
    logic [VIDX_W-1:0] w_idx_nxt;
    logic [VIDX_W-1:0] r_osc_voice;
    logic              r_ready_d;
    logic              r_frame_done;
    logic              r_overrun;
    logic              r_event_drop;

    logic              w_ev;
    logic              w_ev_in_range;
    logic              w_ev_we;
    logic              w_hs;
    logic              w_last;
    logic              w_rd_en;
    logic [VIDX_W-1:0] w_rd_idx;
    logic              w_frame_done_nxt;
    logic              w_cur_gate;
    logic [TUNE_W-1:0] w_cur_tune;
    logic [TUNE_W-1:0] w_cur_phase;
    logic              w_ph_we;
    logic [TUNE_W-1:0] w_ph_data;

    assign w_ev          = SPI_ready_flag & ~r_ready_d;
    assign w_ev_in_range = (SPI_voice_index < 8'(NUM_VOICES));
    assign w_ev_we       = w_ev & w_ev_in_range;
    assign w_hs          = (r_state == SCAN) & osc.osc_ready;
    assign w_last        = (r_idx == VIDX_W'(NUM_VOICES - 1));

    // The adder sees the live table entry, so events that landed while the slot waited count.
    assign w_ph_we   = w_hs & w_cur_gate;
    assign w_ph_data = w_cur_phase + w_cur_tune;

    voice_param_table #(
        .NUM_VOICES (NUM_VOICES),
        .VIDX_W     (VIDX_W),
        .TUNE_W     (TUNE_W),
        .VEL_W      (VEL_W)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .i_ev_we     (w_ev_we),
        .i_ev_status (SPI_note_status),
        .i_ev_idx    (SPI_voice_index[VIDX_W-1:0]),
        .i_ev_tune   (SPI_tuning_code),
        .i_ev_vel    (SPI_velocity),
        .i_ph_we     (w_ph_we),
        .i_idx       (r_idx),
        .i_ph_data   (w_ph_data),
        .o_cur_gate  (w_cur_gate),
        .o_cur_tune  (w_cur_tune),
        .o_cur_phase (w_cur_phase),
        .i_rd_en     (w_rd_en),
        .i_rd_idx    (w_rd_idx),
        .o_rd_gate   (osc.osc_gate),
        .o_rd_vel    (osc.osc_velocity),
        .o_rd_phase  (osc.osc_phase)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_rd_en          = 1'b0;
        w_rd_idx         = r_idx + VIDX_W'(1);
        w_frame_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (sample_tick) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = '0;
                    w_rd_en     = 1'b1;
                    w_rd_idx    = '0;
                end
            end
            SCAN: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_state_nxt      = IDLE;
                        w_frame_done_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + VIDX_W'(1);
                        w_rd_en   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_osc_voice  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_frame_done <= w_frame_done_nxt;
            if (w_rd_en) begin
                r_osc_voice <= w_rd_idx;
            end
        end
    end

    // A tick during SCAN, including the exit cycle, is lost and only recorded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready_d    <= 1'b0;
            r_overrun    <= 1'b0;
            r_event_drop <= 1'b0;
        end else begin
            r_ready_d <= SPI_ready_flag;
            if (sample_tick && (r_state == SCAN)) begin
                r_overrun <= 1'b1;
            end
            if (w_ev && !w_ev_in_range) begin
                r_event_drop <= 1'b1;
            end
        end
    end

    assign osc.osc_valid = (r_state == SCAN);
    assign osc.osc_last  = (r_state == SCAN) && w_last;
    assign osc.osc_voice = r_osc_voice;
    assign frame_done    = r_frame_done;
    assign overrun       = r_overrun;
    assign event_drop    = r_event_drop;

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: a reference voice table predicts every slot per tick,
// and the slot monitor pops and compares predictions at each handshake.
module tb_voice_scheduler;

    localparam int NV = 16;
    localparam int VW = 4;
    localparam int TW = 32;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          SPI_note_status;
    logic [7:0]    SPI_voice_index;
    logic [TW-1:0] SPI_tuning_code;
    logic [LW-1:0] SPI_velocity;
    logic          SPI_ready_flag;
    logic          sample_tick;
    logic          frame_done;
    logic          overrun;
    logic          event_drop;

    voice_scheduler_if #(.VIDX_W(VW), .TUNE_W(TW), .VEL_W(LW)) osc_if ();

    voice_scheduler #(
        .NUM_VOICES (NV),
        .VIDX_W     (VW),
        .TUNE_W     (TW),
        .VEL_W      (LW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .SPI_note_status (SPI_note_status),
        .SPI_voice_index (SPI_voice_index),
        .SPI_tuning_code (SPI_tuning_code),
        .SPI_velocity    (SPI_velocity),
        .SPI_ready_flag  (SPI_ready_flag),
        .sample_tick     (sample_tick),
        .osc             (osc_if),
        .frame_done      (frame_done),
        .overrun         (overrun),
        .event_drop      (event_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] voice;
        logic [TW-1:0] phase;
        logic [LW-1:0] vel;
        logic          gate;
        logic          last;
    } slot_t;

    slot_t         expQ [$];
    slot_t         monSlot;
    logic          mGate  [NV];
    logic [TW-1:0] mTune  [NV];
    logic [TW-1:0] mPhase [NV];
    logic [LW-1:0] mVel   [NV];
    logic          expDrop;
    int            errors = 0;
    int            checks = 0;
    int            frameDoneCount = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic void modelClear();
        for (int v = 0; v < NV; v++) begin
            mGate[v]  = 1'b0;
            mTune[v]  = '0;
            mPhase[v] = '0;
            mVel[v]   = '0;
        end
        expDrop = 1'b0;
    endfunction

    function automatic void modelEvent(input logic on, input logic [7:0] idx,
                                       input logic [TW-1:0] tune, input logic [LW-1:0] vel);
        if (idx >= 8'(NV)) begin
            expDrop = 1'b1;
        end else if (on) begin
            mGate[idx[VW-1:0]]  = 1'b1;
            mTune[idx[VW-1:0]]  = tune;
            mVel[idx[VW-1:0]]   = vel;
            mPhase[idx[VW-1:0]] = '0;
        end else begin
            mGate[idx[VW-1:0]] = 1'b0;
        end
    endfunction

    // One accepted tick: every voice is predicted with its pre-increment phase, then advanced.
    function automatic void pushTickExpect();
        slot_t s;
        for (int v = 0; v < NV; v++) begin
            s.voice = VW'(v);
            s.phase = mPhase[v];
            s.vel   = mVel[v];
            s.gate  = mGate[v];
            s.last  = (v == NV - 1);
            expQ.push_back(s);
            if (mGate[v]) begin
                mPhase[v] = mPhase[v] + mTune[v];
            end
        end
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (osc_if.osc_valid && osc_if.osc_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_slot", 64'(osc_if.osc_voice), 64'hFFFF);
                end else begin
                    monSlot = expQ.pop_front();
                    checkOutput($sformatf("v%0d_voice", monSlot.voice), osc_if.osc_voice, monSlot.voice);
                    checkOutput($sformatf("v%0d_phase", monSlot.voice), osc_if.osc_phase, monSlot.phase);
                    checkOutput($sformatf("v%0d_vel", monSlot.voice), osc_if.osc_velocity, monSlot.vel);
                    checkOutput($sformatf("v%0d_gate", monSlot.voice), osc_if.osc_gate, monSlot.gate);
                    checkOutput($sformatf("v%0d_last", monSlot.voice), osc_if.osc_last, monSlot.last);
                end
            end
            if (frame_done) begin
                frameDoneCount++;
            end
        end
    end

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_valid"}, osc_if.osc_valid, 0);
        checkOutput({pfx, "_voice"}, osc_if.osc_voice, 0);
        checkOutput({pfx, "_phase"}, osc_if.osc_phase, 0);
        checkOutput({pfx, "_vel"}, osc_if.osc_velocity, 0);
        checkOutput({pfx, "_gate"}, osc_if.osc_gate, 0);
        checkOutput({pfx, "_last"}, osc_if.osc_last, 0);
        checkOutput({pfx, "_frame_done"}, frame_done, 0);
        checkOutput({pfx, "_overrun"}, overrun, 0);
        checkOutput({pfx, "_event_drop"}, event_drop, 0);
    endtask

    task automatic applyStimulus(input logic on, input logic [7:0] idx,
                                 input logic [TW-1:0] tune, input logic [LW-1:0] vel);
        @(posedge clk);
        #1;
        SPI_note_status = on;
        SPI_voice_index = idx;
        SPI_tuning_code = tune;
        SPI_velocity    = vel;
        SPI_ready_flag  = 1'b1;
        @(posedge clk);
        #1;
        SPI_ready_flag = 1'b0;
        modelEvent(on, idx, tune, vel);
    endtask

    task automatic waitVoice(input int v, output bit found);
        int n;
        n = 0;
        found = 1'b0;
        while (n < 100) begin
            if (osc_if.osc_valid && (osc_if.osc_voice == VW'(v))) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!found) begin
            checkOutput($sformatf("wait_voice%0d_timeout", v), 0, 1);
        end
    endtask

    // Runs one tick-triggered frame; optional stall, mid-scan tick or colliding note-on (-1 = off).
    task automatic runFrame(input int stallVoice, input int stallCycles, input int overrunVoice,
                            input int collideVoice, input logic [TW-1:0] collideTune,
                            input logic [LW-1:0] collideVel);
        int cycles;
        int framesBefore;
        bit done;
        bit f1;
        bit f2;
        bit f3;
        framesBefore = frameDoneCount;
        @(posedge clk);
        #1;
        sample_tick = 1'b1;
        pushTickExpect();
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        cycles = 0;
        done = 1'b0;
        fork
            begin
                while (!done && cycles < 200) begin
                    @(negedge clk);
                    cycles++;
                    if (frame_done) done = 1'b1;
                end
            end
            begin
                if (stallVoice >= 0) begin
                    waitVoice(stallVoice, f1);
                    if (f1) begin
                        osc_if.osc_ready = 1'b0;
                        for (int c = 0; c < stallCycles; c++) begin
                            @(posedge clk);
                            #1;
                            checkOutput("stall_valid", osc_if.osc_valid, 1);
                            checkOutput("stall_voice", osc_if.osc_voice, stallVoice);
                            if (expQ.size() > 0) begin
                                checkOutput("stall_phase", osc_if.osc_phase, expQ[0].phase);
                                checkOutput("stall_vel", osc_if.osc_velocity, expQ[0].vel);
                            end
                        end
                        osc_if.osc_ready = 1'b1;
                    end
                end
            end
            begin
                if (overrunVoice >= 0) begin
                    waitVoice(overrunVoice, f2);
                    sample_tick = 1'b1;
                    @(posedge clk);
                    #1;
                    sample_tick = 1'b0;
                end
            end
            begin
                if (collideVoice >= 0) begin
                    waitVoice(collideVoice, f3);
                    SPI_note_status = 1'b1;
                    SPI_voice_index = 8'(collideVoice);
                    SPI_tuning_code = collideTune;
                    SPI_velocity    = collideVel;
                    SPI_ready_flag  = 1'b1;
                    @(posedge clk);
                    #1;
                    SPI_ready_flag = 1'b0;
                    modelEvent(1'b1, 8'(collideVoice), collideTune, collideVel);
                end
            end
        join
        checkOutput("frame_done_seen", done, 1);
        checkOutput("frame_len", cycles, NV + 1 + ((stallVoice >= 0) ? stallCycles : 0));
        @(posedge clk);
        #1;
        checkOutput("frame_done_pulse", frame_done, 0);
        checkOutput("frame_done_count", frameDoneCount, framesBefore + 1);
        checkOutput("slots_left", expQ.size(), 0);
        checkOutput("idle_valid", osc_if.osc_valid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        reset            = 1'b1;
        sample_tick      = 1'b0;
        SPI_note_status  = 1'b0;
        SPI_voice_index  = '0;
        SPI_tuning_code  = '0;
        SPI_velocity     = '0;
        SPI_ready_flag   = 1'b0;
        osc_if.osc_ready = 1'b1;
        modelClear();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("rst");
        reset = 1'b1;

        $display("[TB] basic frame");
        applyStimulus(1'b1, 8'd3, 32'h0100_0000, 7'd100);
        repeat (4) runFrame(-1, 0, -1, -1, '0, '0);

        $display("[TB] backpressure");
        runFrame(2, 5, -1, -1, '0, '0);

        $display("[TB] wrap and note-off");
        applyStimulus(1'b1, 8'd9, 32'hC000_0000, 7'd50);
        repeat (3) runFrame(-1, 0, -1, -1, '0, '0);
        applyStimulus(1'b0, 8'd9, '0, '0);
        runFrame(-1, 0, -1, -1, '0, '0);

        $display("[TB] errors");
        checkOutput("drop_before", event_drop, 0);
        applyStimulus(1'b1, 8'd200, 32'h0000_DEAD, 7'd5);
        checkOutput("drop_after", event_drop, expDrop);
        runFrame(-1, 0, -1, -1, '0, '0);
        checkOutput("overrun_before", overrun, 0);
        runFrame(-1, 0, 4, -1, '0, '0);
        checkOutput("overrun_after", overrun, 1);

        $display("[TB] collision");
        applyStimulus(1'b1, 8'd5, 32'h0000_1000, 7'd20);
        runFrame(-1, 0, -1, -1, '0, '0);
        runFrame(-1, 0, -1, 5, 32'h0030_0000, 7'd77);
        repeat (2) runFrame(-1, 0, -1, -1, '0, '0);

        $display("[TB] reset mid-scan");
        @(posedge clk);
        #1;
        sample_tick = 1'b1;
        pushTickExpect();
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        waitVoice(7, found);
        reset = 1'b0;
        #1;
        checkResetOutputs("midrst");
        expQ.delete();
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_rst_idle", osc_if.osc_valid, 0);
        runFrame(-1, 0, -1, -1, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
